// File: rtl/inst_fetch_responder.sv
// Sequential instruction-fetch responder: assembles 32-bit little-endian instructions from
// four byte reads of a synchronous RAM, with a one-entry last-instruction buffer.
module inst_fetch_responder #(
  parameter int unsigned AddrLen    = 32,
  parameter int unsigned InstLen    = 32,
  parameter int unsigned MemAddrLen = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rom_ce_i,
  input  logic [AddrLen-1:0]    rom_addr_i,
  input  logic                  inval_i,
  output logic [InstLen-1:0]    rom_data_o,
  output logic                  rom_ready_o,
  output logic                  error_o,
  output logic [MemAddrLen-1:0] mem_a_o,
  input  logic [7:0]            mem_din_i
);

  typedef enum logic [1:0] {StIdle, StFetch, StResp} state_e;

  state_e                state_q, state_d;
  logic [AddrLen-1:0]    base_q, buf_addr_q;
  logic [InstLen-1:0]    asm_q, rom_data_q, buf_data_q;
  logic [MemAddrLen-1:0] mem_a_q;
  logic [2:0]            k_q;
  logic [1:0]            lane;
  logic                  buf_valid_q, err_q;
  logic                  misaligned, hit, abort, fill;

  always_comb begin
    misaligned = rom_addr_i[1:0] != 2'b00;
    hit        = buf_valid_q && (buf_addr_q == rom_addr_i) && !inval_i;
    // A dropped request or a changed address mid-fetch is a branch redirect.
    abort      = !rom_ce_i || (rom_addr_i != base_q);
    fill       = (state_q == StFetch) && !abort && (k_q == 3'd4);
    lane       = k_q[1:0] - 2'd1;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (rom_ce_i) begin
          state_d = (misaligned || hit) ? StResp : StFetch;
        end
      end
      StFetch: begin
        if (abort) begin
          state_d = StIdle;
        end else if (k_q == 3'd4) begin
          state_d = StResp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rom_ready_o = (state_q == StResp);
    error_o     = (state_q == StResp) && err_q;
    rom_data_o  = rom_data_q;
    mem_a_o     = mem_a_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      base_q      <= '0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      asm_q       <= '0;
      rom_data_q  <= '0;
      mem_a_q     <= '0;
      k_q         <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rom_ce_i) begin
            if (misaligned) begin
              rom_data_q <= '0;
              err_q      <= 1'b1;
            end else if (hit) begin
              rom_data_q <= buf_data_q;
              err_q      <= 1'b0;
            end else begin
              base_q  <= rom_addr_i;
              mem_a_q <= rom_addr_i[MemAddrLen-1:0];
              k_q     <= '0;
              err_q   <= 1'b0;
            end
          end
        end
        StFetch: begin
          if (!abort) begin
            k_q <= k_q + 3'd1;
            if (k_q < 3'd3) begin
              mem_a_q <= base_q[MemAddrLen-1:0] + MemAddrLen'(k_q + 3'd1);
            end
            // RAM data lags the address by one cycle, so step k returns byte k-1.
            if (k_q != 3'd0) begin
              asm_q[{lane, 3'b000} +: 8] <= mem_din_i;
            end
            if (k_q == 3'd4) begin
              rom_data_q <= {mem_din_i, asm_q[23:0]};
              buf_data_q <= {mem_din_i, asm_q[23:0]};
              buf_addr_q <= base_q;
            end
          end
        end
        default: ;
      endcase
      // A completing fill wins over a concurrent invalidate.
      if (fill) begin
        buf_valid_q <= 1'b1;
      end else if (inval_i) begin
        buf_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed self-checking bench for inst_fetch_responder with a byte-wide synchronous RAM model.
module tb_inst_fetch_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic        inval;
  logic [31:0] rom_data;
  logic        rom_ready;
  logic        error;
  logic [16:0] mem_a;
  logic [7:0]  mem_din = 8'h00;

  int total = 0;
  int bad   = 0;
  int lat;

  inst_fetch_responder #(
    .AddrLen   (32),
    .InstLen   (32),
    .MemAddrLen(17)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rom_ce_i   (rom_ce),
    .rom_addr_i (rom_addr),
    .inval_i    (inval),
    .rom_data_o (rom_data),
    .rom_ready_o(rom_ready),
    .error_o    (error),
    .mem_a_o    (mem_a),
    .mem_din_i  (mem_din)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ram_rd(input logic [16:0] a);
    case (a)
      17'h00100: return 8'h13;
      17'h00101: return 8'h05;
      17'h00102: return 8'h10;
      17'h00103: return 8'h00;
      17'h00300: return 8'h93;
      17'h00301: return 8'h02;
      17'h00302: return 8'h50;
      17'h00303: return 8'h00;
      default:   return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clk_in) mem_din <= ram_rd(mem_a);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Leaves any RESP cycle, issues a request from IDLE and returns in its ready cycle.
  task automatic request(input logic [31:0] addr, input logic inv, output int latency);
    rom_ce = 1'b0;
    tick();
    rom_ce   = 1'b1;
    rom_addr = addr;
    inval    = inv;
    latency  = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      inval = 1'b0;
      if (rom_ready) begin
        latency = i;
        break;
      end
    end
    rom_ce = 1'b0;
  endtask

  initial begin
    rst_in   = 1'b0;
    rom_ce   = 1'b0;
    rom_addr = 32'h0;
    inval    = 1'b0;
    tick();
    tick();
    check("rst_ready", {31'b0, rom_ready}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_data", rom_data, 32'h0);
    check("rst_mem_a", {15'b0, mem_a}, 32'h0);
    rst_in = 1'b1;
    tick();

    // Miss with per-cycle address sequence
    rom_ce   = 1'b1;
    rom_addr = 32'h100;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("miss_busy", {31'b0, rom_ready}, 32'd0);
      if (k < 4) check("miss_mem_a", {15'b0, mem_a}, 32'h100 + k);
    end
    tick();
    check("miss_ready", {31'b0, rom_ready}, 32'd1);
    check("miss_data", rom_data, 32'h0010_0513);
    check("miss_error", {31'b0, error}, 32'd0);
    rom_ce = 1'b0;
    tick();
    check("resp_one_cycle", {31'b0, rom_ready}, 32'd0);
    check("data_held", rom_data, 32'h0010_0513);

    request(32'h100, 1'b0, lat);
    check("hit_lat", lat, 32'd1);
    check("hit_data", rom_data, 32'h0010_0513);
    check("hit_mem_a", {15'b0, mem_a}, 32'h103);

    request(32'h100, 1'b1, lat);
    check("inval_lat", lat, 32'd6);
    check("inval_data", rom_data, 32'h0010_0513);

    request(32'h102, 1'b0, lat);
    check("mis_lat", lat, 32'd1);
    check("mis_error", {31'b0, error}, 32'd1);
    check("mis_data", rom_data, 32'h0);
    tick();
    check("mis_error_drop", {31'b0, error}, 32'd0);
    request(32'h100, 1'b0, lat);
    check("post_mis_hit_lat", lat, 32'd1);
    check("post_mis_hit_data", rom_data, 32'h0010_0513);

    // Redirect from 0x200 to 0x300 in the third fetch cycle
    rom_ce = 1'b0;
    tick();
    rom_ce   = 1'b1;
    rom_addr = 32'h200;
    tick();
    tick();
    tick();
    rom_addr = 32'h300;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (rom_ready) begin
        lat = i;
        break;
      end
    end
    rom_ce = 1'b0;
    check("redir_lat", lat, 32'd7);
    check("redir_data", rom_data, 32'h0050_0293);

    // Upper address bits do not reach the RAM
    request(32'h0002_0100, 1'b0, lat);
    check("upper_lat", lat, 32'd6);
    check("upper_data", rom_data, 32'h0010_0513);

    request(32'h100, 1'b0, lat);
    check("refill_lat", lat, 32'd6);
    request(32'h100, 1'b0, lat);
    check("refill_hit_lat", lat, 32'd1);

    // Reset in the third cycle of a miss
    rom_ce = 1'b0;
    tick();
    rom_ce   = 1'b1;
    rom_addr = 32'h300;
    tick();
    tick();
    tick();
    rst_in = 1'b0;
    tick();
    check("mid_rst_ready", {31'b0, rom_ready}, 32'd0);
    check("mid_rst_data", rom_data, 32'h0);
    check("mid_rst_mem_a", {15'b0, mem_a}, 32'h0);
    rst_in = 1'b1;
    rom_ce = 1'b0;
    request(32'h100, 1'b0, lat);
    check("post_rst_lat", lat, 32'd6);
    check("post_rst_data", rom_data, 32'h0010_0513);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
